// File: rtl/song_pkg.sv
//==============================================================================
// Module   : song_pkg
// Brief    : Shared widths, state encoding and ROM-word field helpers.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package song_pkg;

    localparam int SONG_BITS  = 2;
    localparam int IDX_BITS   = 5;
    localparam int NOTE_W     = 6;
    localparam int DUR_W      = 6;
    localparam int ROM_ADDR_W = SONG_BITS + IDX_BITS;
    localparam int WORD_W     = NOTE_W + DUR_W;

    localparam logic [DUR_W-1:0]    END_DUR   = '0;
    localparam logic [NOTE_W-1:0]   REST_NOTE = '0;
    localparam logic [IDX_BITS-1:0] LAST_IDX  = '1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        READ  = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic logic [NOTE_W-1:0] word_note(input logic [WORD_W-1:0] w);
        return w[WORD_W-1:DUR_W];
    endfunction

    function automatic logic [DUR_W-1:0] word_dur(input logic [WORD_W-1:0] w);
        return w[DUR_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/song_reader.sv
//==============================================================================
// Module   : song_reader
// Brief    : Walks one song in the note ROM and issues notes to the player.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module song_reader
    import song_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  play,
    input  logic [SONG_BITS-1:0]  song,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [WORD_W-1:0]     rom_dout,
    input  logic                  note_done,
    output logic                  new_note,
    output logic [NOTE_W-1:0]     note,
    output logic [DUR_W-1:0]      duration,
    output logic                  song_done
);

    state_t                r_state;
    logic [SONG_BITS-1:0]  r_song_q;
    logic [IDX_BITS-1:0]   r_idx;
    logic                  r_pending;

    logic                  w_song_change;
    logic                  w_active;
    logic                  w_advance;

    assign w_song_change = (song != r_song_q);
    assign w_active      = (r_state == FETCH) || (r_state == READ) || (r_state == WAIT);
    // A note_done seen during pause is remembered and acted on once play returns
    assign w_advance     = play && (note_done || r_pending);
    assign rom_addr      = {r_song_q, r_idx};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_song_q  <= '0;
            r_idx     <= '0;
            r_pending <= 1'b0;
            new_note  <= 1'b0;
            song_done <= 1'b0;
            note      <= REST_NOTE;
            duration  <= '0;
        end else begin
            new_note  <= 1'b0;
            song_done <= 1'b0;
            if (w_active && w_song_change) begin
                r_song_q  <= song;
                r_idx     <= '0;
                r_pending <= 1'b0;
                r_state   <= FETCH;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (play) begin
                            r_song_q  <= song;
                            r_idx     <= '0;
                            r_pending <= 1'b0;
                            r_state   <= FETCH;
                        end
                    end
                    FETCH: begin
                        if (play) begin
                            r_state <= READ;
                        end
                    end
                    READ: begin
                        if (word_dur(rom_dout) == END_DUR) begin
                            song_done <= 1'b1;
                            r_state   <= DONE;
                        end else begin
                            note     <= word_note(rom_dout);
                            duration <= word_dur(rom_dout);
                            new_note <= 1'b1;
                            r_state  <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (w_advance) begin
                            r_pending <= 1'b0;
                            if (r_idx == LAST_IDX) begin
                                song_done <= 1'b1;
                                r_state   <= DONE;
                            end else begin
                                r_idx   <= r_idx + IDX_BITS'(1);
                                r_state <= FETCH;
                            end
                        end else if (note_done) begin
                            r_pending <= 1'b1;
                        end
                    end
                    DONE: begin
                        if (!play || w_song_change) begin
                            r_state <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_song_reader.sv
//==============================================================================
// Module   : tb_song_reader
// Brief    : Directed self-checking bench for song_reader with a registered ROM.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_song_reader;
    import song_pkg::*;

    logic                  clk;
    logic                  rst_n;
    logic                  play;
    logic [SONG_BITS-1:0]  song;
    logic [ROM_ADDR_W-1:0] rom_addr;
    logic [WORD_W-1:0]     rom_dout;
    logic                  note_done;
    logic                  new_note;
    logic [NOTE_W-1:0]     note;
    logic [DUR_W-1:0]      duration;
    logic                  song_done;

    logic [WORD_W-1:0]     mem [0:127];

    int n_checks = 0;
    int n_errors = 0;
    int nn       = 0;
    int sd       = 0;
    int maxaddr  = 0;
    int nn0, sd0, nn1, sd1;

    song_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .play      (play),
        .song      (song),
        .rom_addr  (rom_addr),
        .rom_dout  (rom_dout),
        .note_done (note_done),
        .new_note  (new_note),
        .note      (note),
        .duration  (duration),
        .song_done (song_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_dout <= mem[rom_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock; observe outputs on the falling edge
    task automatic step();
        @(negedge clk);
        if (new_note)  nn++;
        if (song_done) sd++;
        if (int'(rom_addr) > maxaddr) maxaddr = int'(rom_addr);
    endtask

    task automatic pulse_done();
        note_done = 1'b1;
        step();
        note_done = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = {6'(i % 64), 6'((i % 31) + 1)};
        mem[0] = {6'd49, 6'd12};
        mem[1] = {6'd1,  6'd8};
        for (int i = 2; i < 28; i++) mem[i] = {6'(i + 10), 6'(i)};
        mem[28] = {6'd5, 6'd0};
        for (int i = 0; i < 32; i++) mem[32 + i] = {6'(i + 20), 6'(i + 1)};
        mem[33] = {6'd0, 6'd5};
        mem[64] = {6'd7, 6'd3};

        rst_n = 1'b0; play = 1'b0; song = '0; note_done = 1'b0;
        step(); step();
        check("rst_new_note",  32'(new_note),  32'd0);
        check("rst_song_done", 32'(song_done), 32'd0);
        check("rst_note",      32'(note),      32'd0);
        check("rst_duration",  32'(duration),  32'd0);
        check("rst_rom_addr",  32'(rom_addr),  32'd0);
        rst_n = 1'b1;
        step();

        // First note and its latency
        play = 1'b1;
        step();
        check("t1_addr0", 32'(rom_addr), 32'd0);
        step();
        check("t1_no_early_note", 32'(new_note), 32'd0);
        step();
        check("t1_new_note", 32'(new_note), 32'd1);
        check("t1_note",     32'(note),     32'd49);
        check("t1_dur",      32'(duration), 32'd12);
        pulse_done();
        check("t1_addr1", 32'(rom_addr), 32'd1);
        step(); step();
        check("t1_note2", 32'(note),     32'd1);
        check("t1_dur2",  32'(duration), 32'd8);

        // Walk to the end-of-song marker at entry 28
        nn0 = nn; sd0 = sd;
        for (int i = 1; i <= 27; i++) begin
            pulse_done(); step(); step();
        end
        check("t2_notes",      32'(nn - nn0), 32'd26);
        check("t2_done_pulse", 32'(song_done), 32'd1);
        check("t2_last_note",  32'(note),      32'd37);
        repeat (5) step();
        check("t2_one_done",   32'(sd - sd0), 32'd1);
        check("t2_no_note",    32'(nn - nn0), 32'd26);
        check("t2_hold_addr",  32'(rom_addr), 32'd28);

        // Full song 1 runs to entry 31
        play = 1'b0; step();
        song = 2'd1; play = 1'b1; step();
        check("t3_addr32", 32'(rom_addr), 32'd32);
        nn0 = nn; sd0 = sd; maxaddr = 0;
        for (int i = 0; i < 32; i++) begin
            step(); step();
            if (i == 1) begin
                check("t3_rest_note", 32'(note),     32'd0);
                check("t3_rest_dur",  32'(duration), 32'd5);
            end
            pulse_done();
        end
        check("t3_notes",   32'(nn - nn0), 32'd32);
        check("t3_done",    32'(sd - sd0), 32'd1);
        check("t3_maxaddr", 32'(maxaddr),  32'd63);

        // Pause in WAIT with a note_done arriving during the pause
        play = 1'b0; step();
        play = 1'b1; step();
        step(); step();
        play = 1'b0;
        pulse_done();
        check("t4_pause_addr", 32'(rom_addr), 32'd32);
        nn1 = nn;
        repeat (5) step();
        check("t4_no_fetch",  32'(nn - nn1), 32'd0);
        check("t4_hold_addr", 32'(rom_addr), 32'd32);
        play = 1'b1; step();
        check("t4_resume_addr", 32'(rom_addr), 32'd33);
        repeat (4) step();
        check("t4_one_note", 32'(nn - nn1), 32'd1);
        check("t4_dur",      32'(duration), 32'd5);

        // Song change in WAIT at song 0 idx 3, with a colliding note_done
        song = 2'd0; step();
        check("t5_restart_addr", 32'(rom_addr), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step(); step(); pulse_done();
        end
        step(); step();
        check("t5_idx3_note", 32'(note), 32'd13);
        sd1 = sd;
        song = 2'd2; note_done = 1'b1;
        step();
        note_done = 1'b0;
        check("t5_addr64",   32'(rom_addr), 32'd64);
        check("t5_note_hold", 32'(note),    32'd13);
        step(); step();
        check("t5_new_note", 32'(new_note), 32'd1);
        check("t5_note",     32'(note),     32'd7);
        check("t5_no_done",  32'(sd - sd1), 32'd0);

        // Asynchronous reset during a new_note cycle
        rst_n = 1'b0;
        #1;
        check("t6_new_note", 32'(new_note), 32'd0);
        check("t6_note",     32'(note),     32'd0);
        check("t6_dur",      32'(duration), 32'd0);
        check("t6_addr",     32'(rom_addr), 32'd0);
        step();
        rst_n = 1'b1; play = 1'b0;
        nn1 = nn;
        repeat (3) step();
        check("t6_idle_addr", 32'(rom_addr), 32'd0);
        check("t6_idle_note", 32'(nn - nn1), 32'd0);
        play = 1'b1; step();
        check("t6_start_addr", 32'(rom_addr), 32'd64);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
